// File: rtl/op_dispatch.sv
// Registered opcode dispatcher: valid/ready opcode in, held one-hot unit enable out.
// Optional build macro OP_DISPATCH_ILLEGAL_TRAP_EN makes an illegal opcode set a sticky err that blocks intake.
module op_dispatch #(
    parameter int SEL_W   = 4,
    parameter int NUM_OPS = 16,
    parameter int LAT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   op_sel,
    input  logic [LAT_W-1:0]   op_lat,
    input  logic               clr_err,
    output logic [NUM_OPS-1:0] en,
    output logic [SEL_W-1:0]   op_cur,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic               err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   op_cur_q, op_cur_d;
    logic [NUM_OPS-1:0] en_q, en_d;
    logic               illegal_q, illegal_d;
    logic               err_q, err_d;

    logic [NUM_OPS-1:0] onehot_sel;
    logic               op_legal;
    logic               accept;
    logic               last_cycle;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_onehot
            assign onehot_sel[gi] = (op_sel == SEL_W'(gi));
        end
    endgenerate

    assign op_legal   = 32'(op_sel) < NUM_OPS;
    assign last_cycle = (cnt_q == '0);
    assign in_ready   = ((state_q == IDLE) || last_cycle) && !err_q;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_cur_d  = op_cur_q;
        en_d      = en_q;
        illegal_d = accept && !op_legal;
`ifdef OP_DISPATCH_ILLEGAL_TRAP_EN
        // Clear wins over a simultaneous illegal accept.
        err_d = clr_err ? 1'b0 : (err_q || (accept && !op_legal));
`else
        err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (accept && op_legal) begin
                    state_d  = ACTIVE;
                    cnt_d    = op_lat;
                    op_cur_d = op_sel;
                    en_d     = onehot_sel;
                end
            end
            ACTIVE: begin
                if (!last_cycle) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else if (accept && op_legal) begin
                    // Reload on the final cycle so the enable switches with no idle gap.
                    cnt_d    = op_lat;
                    op_cur_d = op_sel;
                    en_d     = onehot_sel;
                end else begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    op_cur_d = '0;
                    en_d     = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                op_cur_d = '0;
                en_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_cur_q  <= '0;
            en_q      <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_cur_q  <= op_cur_d;
            en_q      <= en_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

`ifndef OP_DISPATCH_ILLEGAL_TRAP_EN
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
`endif

    assign en      = en_q;
    assign op_cur  = op_cur_q;
    assign busy    = (state_q == ACTIVE);
    assign done    = (state_q == ACTIVE) && last_cycle;
    assign illegal = illegal_q;
    assign err     = err_q;

endmodule

// File: tb/tb_op_dispatch.sv
// Bench for op_dispatch (NUM_OPS=12): directed scenarios plus random traffic against a schedule-based model.
module tb_op_dispatch;

    localparam int SEL_W   = 4;
    localparam int NUM_OPS = 12;
    localparam int LAT_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [SEL_W-1:0]   op_sel = '0;
    logic [LAT_W-1:0]   op_lat = '0;
    logic               clr_err = 1'b0;
    logic [NUM_OPS-1:0] en;
    logic [SEL_W-1:0]   op_cur;
    logic               busy, done, illegal, err;

    int total = 0;
    int bad   = 0;

`ifdef OP_DISPATCH_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    op_dispatch #(.SEL_W(SEL_W), .NUM_OPS(NUM_OPS), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .op_lat(op_lat), .clr_err(clr_err), .en(en),
        .op_cur(op_cur), .busy(busy), .done(done), .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clr_err  = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // {en, op_cur, busy, done, illegal, err, in_ready}
    task automatic test_reset();
        do_reset();
        total++;
        if ({en, op_cur, busy, done, illegal, err, in_ready} !== {12'h000, 4'h0, 5'b00001}) begin
            bad++;
            $display("FAIL reset_state: got en=%h op_cur=%0d busy=%b done=%b ill=%b err=%b rdy=%b want all zero, rdy=1",
                     en, op_cur, busy, done, illegal, err, in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; op_sel = 4'd5; op_lat = 3'd0;
        tick();
        in_valid = 1'b0;
        total++;
        if ({en, op_cur, busy, done} !== {12'h020, 4'd5, 2'b11}) begin
            bad++;
            $display("FAIL single_active: got en=%h op_cur=%0d busy=%b done=%b want en=020 op_cur=5 busy=1 done=1",
                     en, op_cur, busy, done);
        end
        tick();
        total++;
        if ({en, op_cur, busy, done, in_ready} !== {12'h000, 4'd0, 3'b001}) begin
            bad++;
            $display("FAIL single_idle: got en=%h op_cur=%0d busy=%b done=%b rdy=%b want idle",
                     en, op_cur, busy, done, in_ready);
        end
    endtask

    task automatic test_multi();
        in_valid = 1'b1; op_sel = 4'd11; op_lat = 3'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({en, busy, done, in_ready} !== {12'h800, 1'b1, (i == 3), (i == 3)}) begin
                bad++;
                $display("FAIL multi_cycle%0d: got en=%h busy=%b done=%b rdy=%b want en=800 busy=1 done=rdy=%b",
                         i, en, busy, done, in_ready, (i == 3));
            end
            tick();
        end
        total++;
        if ({en, busy} !== {12'h000, 1'b0}) begin
            bad++;
            $display("FAIL multi_end: got en=%h busy=%b want en=000 busy=0", en, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_OPS-1:0] exp_seq [4];
        exp_seq[0] = 12'h004; exp_seq[1] = 12'h004; exp_seq[2] = 12'h200; exp_seq[3] = 12'h000;
        in_valid = 1'b1; op_sel = 4'd2; op_lat = 3'd1;
        tick();
        op_sel = 4'd9; op_lat = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) in_valid = 1'b0;
            total++;
            if (en !== exp_seq[i] || $countones(en) > 1) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got en=%h want en=%h", i, en, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; op_sel = 4'd13; op_lat = 3'd2;
        tick();
        in_valid = 1'b0;
        total++;
        if ({en, busy, illegal, err, in_ready} !== {12'h000, 1'b0, 1'b1, TRAP, !TRAP}) begin
            bad++;
            $display("FAIL illegal_pulse: got en=%h busy=%b ill=%b err=%b rdy=%b want en=000 busy=0 ill=1 err=%b rdy=%b",
                     en, busy, illegal, err, in_ready, TRAP, !TRAP);
        end
        in_valid = 1'b1; op_sel = 4'd3; op_lat = 3'd0;
        if (TRAP) begin
            tick();
            total++;
            if ({en, illegal, err, in_ready} !== {12'h000, 1'b0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL trap_blocked: got en=%h ill=%b err=%b rdy=%b want en=000 ill=0 err=1 rdy=0",
                         en, illegal, err, in_ready);
            end
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            total++;
            if ({en, err, in_ready} !== {12'h000, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL trap_clear: got en=%h err=%b rdy=%b want en=000 err=0 rdy=1", en, err, in_ready);
            end
        end
        tick();
        in_valid = 1'b0;
        total++;
        if ({en, illegal, done} !== {12'h008, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL illegal_recover: got en=%h ill=%b done=%b want en=008 ill=0 done=1", en, illegal, done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; op_sel = 4'd7; op_lat = 3'd5;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({en, op_cur, busy, done} !== {12'h000, 4'd0, 2'b00}) begin
            bad++;
            $display("FAIL async_reset: got en=%h op_cur=%0d busy=%b done=%b want all zero", en, op_cur, busy, done);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({en, busy, done, in_ready} !== {12'h000, 3'b001}) begin
                bad++;
                $display("FAIL async_after%0d: got en=%h busy=%b done=%b rdy=%b want idle rdy=1",
                         i, en, busy, done, in_ready);
            end
            tick();
        end
    endtask

    // Model: each accepted legal op owns a window of cycles [accept+1, accept+1+lat].
    task automatic test_random();
        int busy_until = -1;
        int illegal_cyc = -10;
        int cur_op = 0;
        bit err_m = 1'b0;
        bit exp_busy, exp_done, exp_ill, exp_ready, v, clr, acc, legal;
        logic [NUM_OPS-1:0] exp_en;
        int exp_op, sel, lat;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            exp_busy  = (c <= busy_until);
            exp_en    = exp_busy ? (NUM_OPS'(1) << cur_op) : '0;
            exp_op    = exp_busy ? cur_op : 0;
            exp_done  = (c == busy_until);
            exp_ill   = (c == illegal_cyc);
            exp_ready = (busy_until <= c) && !err_m;
            total++;
            if (en !== exp_en || op_cur !== SEL_W'(exp_op) || busy !== exp_busy || done !== exp_done ||
                illegal !== exp_ill || err !== err_m || in_ready !== exp_ready) begin
                bad++;
                $display("FAIL rand_cycle%0d: got en=%h op=%0d busy=%b done=%b ill=%b err=%b rdy=%b want en=%h op=%0d busy=%b done=%b ill=%b err=%b rdy=%b",
                         c, en, op_cur, busy, done, illegal, err, in_ready,
                         exp_en, exp_op, exp_busy, exp_done, exp_ill, err_m, exp_ready);
            end
            v   = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 15);
            lat = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 7);
            clr = ($urandom_range(0, 5) == 0);
            in_valid = v; op_sel = SEL_W'(sel); op_lat = LAT_W'(lat); clr_err = clr;
            acc   = v && exp_ready;
            legal = (sel < NUM_OPS);
            if (acc) begin
                if (legal) begin
                    cur_op     = sel;
                    busy_until = c + 1 + lat;
                end else begin
                    illegal_cyc = c + 1;
                end
                $display("txn cycle=%0d op=%0d lat=%0d %s", c, sel, lat, legal ? "dispatch" : "illegal");
            end
            if (TRAP) begin
                if (clr) err_m = 1'b0;
                else if (acc && !legal) err_m = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/op_dispatch.md
# op_dispatch

Parametrised, registered successor to the team's combinational opcode-to-enable decoder. It accepts an opcode over a valid/ready handshake and drives a registered one-hot enable vector to the ALU functional units. The enable is held for a per-request programmable number of cycles to support multi-cycle units. It also reports completion and out-of-range opcodes. It sits between the instruction/control front end and the ALU datapath.

## Interface
- SEL_W, 4, opcode width
- NUM_OPS, 16, number of dispatchable units; 2 ≤ NUM_OPS ≤ 2**SEL_W
- LAT_W, 3, width of the hold-count field
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- op_sel  in  SEL_W  opcode; en bit index
- op_lat  in  LAT_W  extra hold cycles; enable lasts op_lat+1 cycles
- clr_err  in  1  clears sticky error (trap build only; ignored otherwise)
- en  out  NUM_OPS  registered one-hot unit enable; all-zero when idle
- op_cur  out  SEL_W  opcode currently dispatched; 0 when idle
- busy  out  1  an enable is being driven
- done  out  1  final cycle of the current enable
- illegal  out  1  one-cycle pulse: out-of-range opcode consumed
- err  out  1  sticky illegal flag (trap build only; tied 0 otherwise)

## Operation
- Opcode is legal when op_sel < NUM_OPS.
- Accept occurs when in_valid && in_ready. in_valid/op_sel/op_lat are sampled only on accept.
- FSM states:
  - IDLE: en=0, busy=0, in_ready=1 (unless err is set in trap build).
  - ACTIVE: en=onehot(op_cur), busy=1, hold counter cnt counts down.
- in_ready = (IDLE || (ACTIVE && cnt==0)) && !err. Back-to-back dispatch is allowed on the final enable cycle.
- done = ACTIVE && cnt==0. It is a decode of registered state only; no input-to-output combinational path.
- Accept of a legal op:
  - next cycle en=onehot(op_sel), op_cur=op_sel, cnt=op_lat, state ACTIVE.
- ACTIVE with cnt>0: cnt decrements.
- ACTIVE with cnt==0:
  - With a legal accept: reload for the new op. en switches directly to the new one-hot with no zero gap.
  - Otherwise: go to IDLE, en=0, op_cur=0.
- Accept of an illegal op:
  - No en bit is set.
  - illegal=1 for exactly the next cycle.
  - FSM goes to IDLE, or stays IDLE.
- en is never multi-hot. At most one bit is set in any cycle.
- op_lat is unsigned; the maximum hold is 2**LAT_W cycles. No wrap-around: cnt saturates at 0 and moves to the next state.

## Timing
- Reset values: en=0, op_cur=0, busy=0, done=0, illegal=0, err=0, state IDLE, cnt=0. in_ready=1 once rst_n deasserts.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). The in-flight op is abandoned and done is not issued.
- Dispatch latency: accept on edge k → en valid from edge k+1, for op_lat+1 cycles. done coincides with the last of those cycles.
- Sustained throughput: one op per op_lat+1 cycles.
- Illegal accept on edge k → illegal high from k+1 to k+2.

## Configuration
- OP_DISPATCH_ILLEGAL_TRAP_EN defined:
  - An illegal accept also sets err.
  - While err=1: in_ready=0, and no further requests are accepted.
  - An op already in flight completes normally.
  - clr_err=1 at an edge clears err; clearing takes priority over a simultaneous set.
- Not defined:
  - err is tied 0 and clr_err is ignored.
  - Illegal ops are pulsed on illegal and dropped; dispatch continues.

## Test plan
- Reset then legal op: SEL_W=4, NUM_OPS=16; op_sel=5, op_lat=0, one-cycle valid → en=16'h0020 for 1 cycle; done in that cycle; then idle.
- Multi-cycle op: op_sel=0xF, op_lat=3 → en=16'h8000 for 4 cycles; in_ready low for the first 3; done on the 4th.
- Back-to-back: op 2 (lat 1), then op 9 presented valid continuously → en 0x0004 for 2 cycles, then 0x0200 with no gap; en never multi-hot.
- Illegal: NUM_OPS=12, op_sel=13 → en stays 0; illegal pulses once.
  - Trap build: err=1 and in_ready=0 until clr_err; afterwards op_sel=3 dispatches en=12'h008.
- Async reset: assert rst_n=0 in cycle 2 of op_lat=5 → en, busy, op_cur clear without waiting for clk; no done; in_ready=1 after release.
